// File: rtl/cla_pkg.sv
// Shared defaults and parameter helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam int unsigned DEF_WIDTH  = 16;
    localparam int unsigned DEF_GROUP  = 4;
    localparam int unsigned DEF_STAGES = 2;

    // Groups handled by each pipeline stage; zero for degenerate configurations.
    function automatic int unsigned groups_per_stage(
        input int unsigned width,
        input int unsigned group,
        input int unsigned stages
    );
        if (group == 0 || stages == 0) begin
            return 0;
        end
        return (width / group) / stages;
    endfunction

    function automatic bit cfg_legal(
        input int unsigned width,
        input int unsigned group,
        input int unsigned stages
    );
        if (width == 0 || group == 0 || stages == 0) begin
            return 1'b0;
        end
        return ((width % group) == 0) && (((width / group) % stages) == 0);
    endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit combinational carry-lookahead block with carry-in, group generate and propagate.
module cla_group #(
    parameter int unsigned GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             g,
    output logic             p
);

    logic [GROUP-1:0] bit_g;
    logic [GROUP-1:0] bit_p;
    logic [GROUP-1:0] pre_g;
    logic [GROUP-1:0] pre_p;
    logic [GROUP-1:0] carry;

    // Prefix generate/propagate over bits [0..i]; kept free of cin so group G/P never waits on it.
    always_comb begin
        bit_g    = a & b;
        bit_p    = a ^ b;
        pre_g    = '0;
        pre_p    = '0;
        pre_g[0] = bit_g[0];
        pre_p[0] = bit_p[0];
        for (int i = 1; i < int'(GROUP); i++) begin
            pre_g[i] = bit_g[i] | (bit_p[i] & pre_g[i-1]);
            pre_p[i] = bit_p[i] & pre_p[i-1];
        end
    end

    // Every internal carry is a two-level function of the prefix terms and cin.
    always_comb begin
        carry    = '0;
        carry[0] = cin;
        for (int i = 1; i < int'(GROUP); i++) begin
            carry[i] = pre_g[i-1] | (pre_p[i-1] & cin);
        end
        sum = bit_p ^ carry;
    end

    assign g = pre_g[GROUP-1];
    assign p = pre_p[GROUP-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: LSB groups resolve first, one stage per cycle,
// with a registered inter-stage carry and valid/ready flow control on a global advance enable.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned GROUP  = DEF_GROUP,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NGRP  = WIDTH / GROUP;
    localparam int unsigned GPS   = groups_per_stage(WIDTH, GROUP, STAGES);
    localparam int unsigned SBITS = GPS * GROUP;

    if (!cfg_legal(WIDTH, GROUP, STAGES)) begin : g_bad_cfg
        $fatal(1, "pipelined_cla_adder: WIDTH must be a multiple of GROUP and WIDTH/GROUP a multiple of STAGES");
    end

    logic             en;

    // Stage output registers; operand copies carry the bits later stages still need.
    logic             v_q   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             o_q   [STAGES];

    // Stage inputs (b already conditioned for subtract) and stage results.
    logic             st_v    [STAGES];
    logic [WIDTH-1:0] st_a    [STAGES];
    logic [WIDTH-1:0] st_b    [STAGES];
    logic [WIDTH-1:0] st_s    [STAGES];
    logic             st_c    [STAGES];
    logic             st_cout [STAGES];
    logic             st_ovf  [STAGES];
    logic [WIDTH-1:0] nxt_s   [STAGES];

    logic [NGRP-1:0]  grp_g;
    logic [NGRP-1:0]  grp_p;
    logic [NGRP-1:0]  grp_cin;
    logic [WIDTH-1:0] grp_sum;
    logic             lk_g;
    logic             lk_p;

    assign en        = out_ready | ~v_q[STAGES-1];
    assign in_ready  = en;
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = o_q[STAGES-1];

    // Stage 0 works on the port operands; later stages on the previous stage's registers.
    always_comb begin
        st_v[0] = in_valid;
        st_a[0] = a;
        st_b[0] = sub ? ~b : b;
        st_c[0] = sub ? 1'b1 : cin;
        st_s[0] = '0;
        for (int s = 1; s < int'(STAGES); s++) begin
            st_v[s] = v_q[s-1];
            st_a[s] = a_q[s-1];
            st_b[s] = b_q[s-1];
            st_c[s] = c_q[s-1];
            st_s[s] = s_q[s-1];
        end
    end

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        localparam int unsigned STG = k / GPS;
        cla_group #(
            .GROUP (GROUP)
        ) u_grp (
            .a   (st_a[STG][k*GROUP +: GROUP]),
            .b   (st_b[STG][k*GROUP +: GROUP]),
            .cin (grp_cin[k]),
            .sum (grp_sum[k*GROUP +: GROUP]),
            .g   (grp_g[k]),
            .p   (grp_p[k])
        );
    end

    // Group-level lookahead: each group's carry-in from the prefix G/P of lower groups in its stage.
    always_comb begin
        grp_cin = '0;
        lk_g    = 1'b0;
        lk_p    = 1'b1;
        for (int s = 0; s < int'(STAGES); s++) begin
            lk_g = 1'b0;
            lk_p = 1'b1;
            for (int j = 0; j < int'(GPS); j++) begin
                grp_cin[s*GPS+j] = lk_g | (lk_p & st_c[s]);
                lk_g             = grp_g[s*GPS+j] | (grp_p[s*GPS+j] & lk_g);
                lk_p             = lk_p & grp_p[s*GPS+j];
            end
            st_cout[s] = lk_g | (lk_p & st_c[s]);
        end
    end

    // Merge this stage's sum slice; carry into the stage's top bit recovered as sum^a^b.
    always_comb begin
        for (int s = 0; s < int'(STAGES); s++) begin
            nxt_s[s]                     = st_s[s];
            nxt_s[s][s*SBITS +: SBITS]   = grp_sum[s*SBITS +: SBITS];
            st_ovf[s] = st_cout[s] ^ (grp_sum[(s+1)*SBITS-1]
                                      ^ st_a[s][(s+1)*SBITS-1]
                                      ^ st_b[s][(s+1)*SBITS-1]);
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q[s] <= 1'b0;
                a_q[s] <= '0;
                b_q[s] <= '0;
                s_q[s] <= '0;
                c_q[s] <= 1'b0;
                o_q[s] <= 1'b0;
            end else if (en) begin
                v_q[s] <= st_v[s];
                a_q[s] <= st_a[s];
                b_q[s] <= st_b[s];
                s_q[s] <= nxt_s[s];
                c_q[s] <= st_cout[s];
                o_q[s] <= st_ovf[s];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench: directed vectors, flow control and reset on STAGES=2, plus
// randomized traffic on STAGES=1, 2 and 4 against an arithmetic reference model.
module tb_pipelined_cla_adder;

    localparam int unsigned W  = 16;
    localparam int unsigned ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid  [ND];
    logic         in_ready  [ND];
    logic [W-1:0] a_i       [ND];
    logic [W-1:0] b_i       [ND];
    logic         cin_i     [ND];
    logic         sub_i     [ND];
    logic         out_valid [ND];
    logic         out_ready [ND];
    logic [W-1:0] sum_o     [ND];
    logic         cout_o    [ND];
    logic         ovf_o     [ND];

    int n_checks = 0;
    int n_fail   = 0;

    logic [W+1:0] q0[$];
    logic [W+1:0] q1[$];
    logic [W+1:0] q2[$];

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4), .STAGES(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_i[0]), .b(b_i[0]), .cin(cin_i[0]), .sub(sub_i[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0])
    );

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4), .STAGES(2)) u_dut_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_i[1]), .b(b_i[1]), .cin(cin_i[1]), .sub(sub_i[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1])
    );

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4), .STAGES(4)) u_dut_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a_i[2]), .b(b_i[2]), .cin(cin_i[2]), .sub(sub_i[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(sum_o[2]), .cout(cout_o[2]), .ovf(ovf_o[2])
    );

    // Reference: {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic sb);
        int          sx;
        int          sy;
        int          r;
        logic [W:0]  u;
        logic        co;
        logic        ov;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (sb) begin
            r  = sx - sy;
            u  = 17'(x) - 17'(y);
            co = (x >= y);
        end else begin
            r  = sx + sy + int'(ci);
            u  = 17'(x) + 17'(y) + 17'(ci);
            co = u[W];
        end
        ov = (r > 32767) || (r < -32768);
        return {ov, co, u[W-1:0]};
    endfunction

    function automatic logic [W+1:0] obs(input int k);
        return {ovf_o[k], cout_o[k], sum_o[k]};
    endfunction

    function automatic void sb_push(input int k, input logic [W+1:0] v);
        case (k)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic int sb_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [W+1:0] sb_pop(input int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic idle_all();
        for (int k = 0; k < int'(ND); k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
            a_i[k]       = '0;
            b_i[k]       = '0;
            cin_i[k]     = 1'b0;
            sub_i[k]     = 1'b0;
        end
    endtask

    task automatic drive_rand(input int k);
        a_i[k]   = W'($urandom);
        b_i[k]   = W'($urandom);
        cin_i[k] = 1'($urandom_range(0, 1));
        sub_i[k] = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        idle_all();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < int'(ND); k++) begin
            n_checks++;
            if (out_valid[k] !== 1'b0 || obs(k) !== '0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: out_valid=%b result=%h, required 0/0", k, out_valid[k], obs(k));
            end
        end
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < int'(ND); k++) begin
            n_checks++;
            if (in_ready[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_in_ready dut%0d: in_ready=%b, required 1", k, in_ready[k]);
            end
        end
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [3] = '{16'hFFFF, 16'h7FFF, 16'h0005};
        logic [W-1:0] vb [3] = '{16'h0001, 16'h0001, 16'h0007};
        logic         vs [3] = '{1'b0, 1'b0, 1'b1};
        logic [W+1:0] ve [3] = '{18'h10000, 18'h28000, 18'h0FFFE};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid[1] = 1'b1;
            a_i[1]      = va[i];
            b_i[1]      = vb[i];
            cin_i[1]    = 1'b0;
            sub_i[1]    = vs[i];
            @(negedge clk);
            in_valid[1] = 1'b0;
            n_checks++;
            if (out_valid[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL vec%0d_early out_valid=%b one cycle after accept, required 0", i, out_valid[1]);
            end
            @(negedge clk);
            n_checks++;
            if (out_valid[1] !== 1'b1 || obs(1) !== ve[i]) begin
                n_fail++;
                $display("FAIL vec%0d_result out_valid=%b {ovf,cout,sum}=%h, required 1/%h", i, out_valid[1], obs(1), ve[i]);
            end
            @(negedge clk);
            n_checks++;
            if (out_valid[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL vec%0d_single out_valid=%b after result, required 0", i, out_valid[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] exp [8];
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c < 8) begin
                drive_rand(1);
                in_valid[1] = 1'b1;
                exp[c]      = model(a_i[1], b_i[1], cin_i[1], sub_i[1]);
            end else begin
                in_valid[1] = 1'b0;
            end
            n_checks++;
            if (c >= 2 && c < 10) begin
                if (out_valid[1] !== 1'b1 || obs(1) !== exp[c-2]) begin
                    n_fail++;
                    $display("FAIL b2b_beat%0d out_valid=%b result=%h, required 1/%h", c - 2, out_valid[1], obs(1), exp[c-2]);
                end
            end else if (out_valid[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_idle cycle%0d out_valid=%b, required 0", c, out_valid[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ba [4];
        logic [W-1:0] bb [4];
        logic         bc [4];
        logic         bs [4];
        logic [W+1:0] bexp [4];
        int           sent = 0;
        int           got  = 0;
        for (int i = 0; i < 4; i++) begin
            ba[i]   = W'($urandom);
            bb[i]   = W'($urandom);
            bc[i]   = 1'($urandom_range(0, 1));
            bs[i]   = 1'($urandom_range(0, 1));
            bexp[i] = model(ba[i], bb[i], bc[i], bs[i]);
        end
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            out_ready[1] = (c >= 2 && c < 5) ? 1'b0 : 1'b1;
            if (sent < 4) begin
                in_valid[1] = 1'b1;
                a_i[1]      = ba[sent];
                b_i[1]      = bb[sent];
                cin_i[1]    = bc[sent];
                sub_i[1]    = bs[sent];
            end else begin
                in_valid[1] = 1'b0;
            end
            #1;
            if (c >= 2 && c < 5) begin
                n_checks++;
                if (in_ready[1] !== 1'b0 || out_valid[1] !== 1'b1 || obs(1) !== bexp[0]) begin
                    n_fail++;
                    $display("FAIL stall_freeze cycle%0d in_ready=%b out_valid=%b result=%h, required 0/1/%h",
                             c, in_ready[1], out_valid[1], obs(1), bexp[0]);
                end
            end
            if (out_valid[1] && out_ready[1]) begin
                n_checks++;
                if (got >= 4) begin
                    n_fail++;
                    $display("FAIL stall_dup extra result %h after all 4 drained", obs(1));
                end else if (obs(1) !== bexp[got]) begin
                    n_fail++;
                    $display("FAIL stall_drain beat%0d result=%h, required %h", got, obs(1), bexp[got]);
                end
                got++;
            end
            if (in_valid[1] && in_ready[1]) begin
                sent++;
            end
        end
        n_checks++;
        if (got != 4 || sent != 4) begin
            n_fail++;
            $display("FAIL stall_count results=%0d accepted=%0d, required 4/4", got, sent);
        end
        idle_all();
    endtask

    task automatic test_reset_inflight();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive_rand(1);
            in_valid[1] = 1'b1;
        end
        @(negedge clk);
        in_valid[1] = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < int'(ND); k++) begin
            n_checks++;
            if (out_valid[k] !== 1'b0 || obs(k) !== '0) begin
                n_fail++;
                $display("FAIL rst_async dut%0d out_valid=%b result=%h, required 0/0", k, out_valid[k], obs(k));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release_ready in_ready=%b, required 1", in_ready[1]);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_stale cycle%0d out_valid=%b result=%h, required 0", c, out_valid[1], obs(1));
            end
        end
    endtask

    task automatic test_random(input int cycles);
        logic         stalled [ND];
        logic [W+1:0] held    [ND];
        logic [W+1:0] exp;
        for (int k = 0; k < int'(ND); k++) begin
            stalled[k] = 1'b0;
            held[k]    = '0;
        end
        for (int cyc = 0; cyc < cycles + 20; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < int'(ND); k++) begin
                if (cyc < cycles) begin
                    out_ready[k] = ($urandom_range(0, 3) != 0);
                    in_valid[k]  = ($urandom_range(0, 3) != 0);
                    drive_rand(k);
                end else begin
                    out_ready[k] = 1'b1;
                    in_valid[k]  = 1'b0;
                end
            end
            #1;
            for (int k = 0; k < int'(ND); k++) begin
                if (stalled[k]) begin
                    n_checks++;
                    if (out_valid[k] !== 1'b1 || obs(k) !== held[k]) begin
                        n_fail++;
                        $display("FAIL rand_hold dut%0d cycle%0d out_valid=%b result=%h, required 1/%h",
                                 k, cyc, out_valid[k], obs(k), held[k]);
                    end
                end
                if (out_valid[k] && out_ready[k]) begin
                    n_checks++;
                    if (sb_size(k) == 0) begin
                        n_fail++;
                        $display("FAIL rand_extra dut%0d cycle%0d result=%h with no beat outstanding", k, cyc, obs(k));
                    end else begin
                        exp = sb_pop(k);
                        if (obs(k) !== exp) begin
                            n_fail++;
                            $display("FAIL rand_result dut%0d cycle%0d result=%h, required %h", k, cyc, obs(k), exp);
                        end
                    end
                end
                stalled[k] = out_valid[k] && !out_ready[k];
                held[k]    = obs(k);
                if (in_valid[k] && in_ready[k]) begin
                    sb_push(k, model(a_i[k], b_i[k], cin_i[k], sub_i[k]));
                end
            end
        end
        for (int k = 0; k < int'(ND); k++) begin
            n_checks++;
            if (sb_size(k) != 0 || out_valid[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_lost dut%0d outstanding=%0d out_valid=%b, required 0/0", k, sb_size(k), out_valid[k]);
            end
        end
        idle_all();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
        test_reset();
        test_vectors();
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
        test_random(30000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
